esp_resp_parser: RTL
====================

# esp_resp_parser

Receive-side decoder for the ESP AT link: consumes bytes from the ESP-facing UART receiver and recognises the module's line-oriented responses. It is the counterpart of the AT-command sender: the sender issues commands, this block reports `OK`, `ERROR` and `+IPD` network payloads back to control logic. It sits between the ESP `uart_rx` byte output and the application; the raw byte path to the PC bridge is unaffected.

## Interface
Parameters:
- `MAX_IPD_LEN`, 1024: largest accepted `+IPD` payload length in bytes.
- `TIMEOUT_CYC`, 50_000_000: idle cycles (1 s at 50 MHz) after which a partial line or payload is abandoned.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx_byte`  in  8  received byte from the ESP UART receiver.
- `rx_byte_vld`  in  1  one-cycle strobe; `rx_byte` is valid this cycle.
- `ok_pulse`  out  1  complete `OK\r\n` line seen.
- `err_pulse`  out  1  complete `ERROR\r\n` line seen.
- `ipd_start`  out  1  valid `+IPD,<n>:` header accepted; `ipd_len` is valid.
- `ipd_len`  out  16  payload length from the latest accepted header; holds until the next header.
- `ipd_data`  out  8  payload byte.
- `ipd_vld`  out  1  `ipd_data` is valid.
- `ipd_done`  out  1  last payload byte delivered.
- `fmt_err`  out  1  malformed `+IPD` header.
- `tmo_pulse`  out  1  timeout abandoned a partial line or payload.
- `ipd_busy`  out  1  high in LEN and DATA states.

## Operation
- States: IDLE (line start), KW (matching keyword), LEN (decimal length), DATA (payload forward), SKIP (discard until `\n`).
- IDLE: `\r`/`\n` ignored. `O` → KW(OK). `E` → KW(ERROR). `+` → KW(IPD). Any other byte → SKIP.
- KW: an index counter compares each byte against the remaining expected sequence: `K\r\n`, `RROR\r\n` or `IPD,`. On mismatch → SKIP; if the mismatching byte is `\n`, go directly to IDLE. On the final `\n` of OK/ERROR, pulse `ok_pulse`/`err_pulse` → IDLE. On the `,` of `IPD,` → LEN with accumulator cleared.
- LEN: digit → `acc = acc*10 + digit`, counting digits. `:` after 1–5 digits with `1 ≤ acc ≤ MAX_IPD_LEN` → latch `ipd_len`, pulse `ipd_start`, load the remaining-byte counter → DATA. In every other case pulse `fmt_err` → SKIP, or → IDLE if the byte was `\n`. Failing cases: non-digit, 6th digit, `:` with zero digits, out-of-range value.
- DATA: every byte is forwarded unmodified, including `\r`, `\n`, `O` and `+`, with no keyword matching. The last byte also pulses `ipd_done` → IDLE.
- SKIP: discard bytes until `\n` → IDLE.
- Timeout: an idle counter clears on each `rx_byte_vld` and counts while the state ≠ IDLE. When it reaches `TIMEOUT_CYC`, pulse `tmo_pulse` → IDLE. In DATA, `ipd_done` is not asserted.
- Bytes arriving while `rx_byte_vld` = 0 are never sampled.

## Timing
- All outputs are registered. Every pulse is exactly 1 cycle, asserted the cycle after the sampled `rx_byte_vld` that caused it.
- `ipd_data`/`ipd_vld`: 1-cycle latency from input. `ipd_done` is coincident with the last `ipd_vld`.
- `ipd_start` precedes the first `ipd_vld` by at least one byte time.
- Back-to-back `rx_byte_vld` on consecutive cycles is supported: one byte is processed per cycle.
- Reset values: all pulses and `ipd_vld`/`ipd_busy` = 0, `ipd_data` = 0, `ipd_len` = 0, state IDLE, counters 0. Asserting reset mid-payload abandons it silently.
- A timeout and a byte arriving on the same cycle: the byte wins, and the counter clears.
- Length arithmetic uses 17 bits internally (5 digits ≤ 99999). The range check is applied before truncating to 16 bits.

## Structure
- Shared package `esp_at_pkg`: ASCII constants (`CR`, `LF`, `COLON`, `COMMA`, `PLUS`), the keyword byte sequences and the state enum.
- One sub-module, `rx_idle_timer`: parameterised by `TIMEOUT_CYC`, with inputs `clr` and `run` and a 1-cycle `expired` output.

## Test plan
- `O K \r \n` → exactly one `ok_pulse` the cycle after `\n`; no other pulses.
- `OKAY\r\n` then `ERROR\r\n` → no `ok_pulse`; one `err_pulse`.
- `+IPD,3:a\r\n` → `ipd_start` with `ipd_len`=3. Then `ipd_vld` ×3 carrying 0x61, 0x0D, 0x0A, with `ipd_done` on the third; no `ok_pulse` is raised.
- `+IPD,0:` and `+IPD,1025:` → `fmt_err`, no `ipd_start`. A following `OK\r\n` still gives `ok_pulse`.
- `+IPD,4:ab`, then silence for `TIMEOUT_CYC` → 2 `ipd_vld`, then `tmo_pulse`, no `ipd_done`, state returns to IDLE.
- Reset asserted mid-payload, then `OK\r\n` → outputs 0 during reset; `ok_pulse` afterwards.

Source files
------------

// File: rtl/esp_at_pkg.sv
// Shared definitions for the ESP AT link receive path.
// Contents: ASCII byte constants, the response parser state enum, the keyword
// selector enum and helpers returning the expected keyword byte sequences
// (the tail that follows the already-matched leading byte).
package esp_at_pkg;

    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] COLON = 8'h3A;
    localparam logic [7:0] COMMA = 8'h2C;
    localparam logic [7:0] PLUS  = 8'h2B;
    localparam logic [7:0] CH_O  = 8'h4F;
    localparam logic [7:0] CH_E  = 8'h45;
    localparam logic [7:0] CH_K  = 8'h4B;
    localparam logic [7:0] CH_R  = 8'h52;
    localparam logic [7:0] CH_I  = 8'h49;
    localparam logic [7:0] CH_P  = 8'h50;
    localparam logic [7:0] CH_D  = 8'h44;

    typedef enum logic [2:0] {
        StIdle,
        StKw,
        StLen,
        StData,
        StSkip
    } parse_state_e;

    typedef enum logic [1:0] {
        KwOk,
        KwErr,
        KwIpd
    } kw_sel_e;

    // Expected byte at position idx of the keyword tail: "K\r\n", "RROR\r\n", "IPD,".
    function automatic logic [7:0] kw_byte(input kw_sel_e kw, input logic [2:0] idx);
        logic [7:0] b;
        b = LF;
        case (kw)
            KwOk: begin
                case (idx)
                    3'd0:    b = CH_K;
                    3'd1:    b = CR;
                    default: b = LF;
                endcase
            end
            KwErr: begin
                case (idx)
                    3'd0, 3'd1, 3'd3: b = CH_R;
                    3'd2:             b = CH_O;
                    3'd4:             b = CR;
                    default:          b = LF;
                endcase
            end
            KwIpd: begin
                case (idx)
                    3'd0:    b = CH_I;
                    3'd1:    b = CH_P;
                    3'd2:    b = CH_D;
                    default: b = COMMA;
                endcase
            end
            default: b = LF;
        endcase
        return b;
    endfunction

    // Index of the final byte of each keyword tail.
    function automatic logic [2:0] kw_last(input kw_sel_e kw);
        logic [2:0] last;
        case (kw)
            KwOk:    last = 3'd2;
            KwErr:   last = 3'd5;
            default: last = 3'd3;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/rx_idle_timer.sv
// Idle timer for the ESP response parser.
// Counts cycles while run is high and clr is low; expired is high for the one
// cycle on which TIMEOUT_CYC such cycles have elapsed, then the count restarts.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the count (a byte was received)
//   run        : count enable (parser is mid-line or mid-payload)
//   expired    : timeout reached this cycle
module rx_idle_timer #(
    parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    logic [CntW-1:0] cnt;

    // clr gates expiry so that a byte on the timeout cycle wins.
    assign expired = run && !clr && (cnt == CntW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || !run || expired) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CntW'(1);
        end
    end

endmodule

// File: rtl/esp_resp_parser.sv
// Receive-side decoder for the ESP AT link.
// Recognises "OK\r\n", "ERROR\r\n" and "+IPD,<n>:<payload>" in the byte stream
// from the ESP UART receiver and reports them to control logic.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   rx_byte/rx_byte_vld : received byte and its one-cycle strobe
//   ok_pulse, err_pulse : complete OK / ERROR line seen
//   ipd_start, ipd_len  : accepted +IPD header and its payload length
//   ipd_data, ipd_vld   : forwarded payload byte
//   ipd_done            : last payload byte (coincident with ipd_vld)
//   fmt_err             : malformed +IPD header
//   tmo_pulse           : partial line or payload abandoned after idle timeout
//   ipd_busy            : parsing a length or forwarding a payload
module esp_resp_parser
    import esp_at_pkg::*;
#(
    parameter int unsigned MAX_IPD_LEN = 1024,
    parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_byte,
    input  logic        rx_byte_vld,
    output logic        ok_pulse,
    output logic        err_pulse,
    output logic        ipd_start,
    output logic [15:0] ipd_len,
    output logic [7:0]  ipd_data,
    output logic        ipd_vld,
    output logic        ipd_done,
    output logic        fmt_err,
    output logic        tmo_pulse,
    output logic        ipd_busy
);

    localparam logic [16:0] MaxLen = 17'(MAX_IPD_LEN);

    parse_state_e state;
    kw_sel_e      kw;
    logic [2:0]   idx;
    logic [16:0]  acc;
    logic [2:0]   dcnt;
    logic [15:0]  rem;
    logic         tmo_expired;

    logic         is_digit;
    logic [16:0]  acc_next;
    logic         len_ok;

    assign is_digit = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
    // ASCII digits carry their value in the low nibble.
    assign acc_next = (acc * 17'd10) + {13'd0, rx_byte[3:0]};
    // Range check on the full 17-bit value, before truncation to ipd_len.
    assign len_ok   = (dcnt != 3'd0) && (acc >= 17'd1) && (acc <= MaxLen);
    assign ipd_busy = (state == StLen) || (state == StData);

    rx_idle_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_idle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (rx_byte_vld),
        .run     (state != StIdle),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            kw        <= KwOk;
            idx       <= '0;
            acc       <= '0;
            dcnt      <= '0;
            rem       <= '0;
            ok_pulse  <= 1'b0;
            err_pulse <= 1'b0;
            ipd_start <= 1'b0;
            ipd_len   <= '0;
            ipd_data  <= '0;
            ipd_vld   <= 1'b0;
            ipd_done  <= 1'b0;
            fmt_err   <= 1'b0;
            tmo_pulse <= 1'b0;
        end else begin
            ok_pulse  <= 1'b0;
            err_pulse <= 1'b0;
            ipd_start <= 1'b0;
            ipd_vld   <= 1'b0;
            ipd_done  <= 1'b0;
            fmt_err   <= 1'b0;
            tmo_pulse <= 1'b0;

            if (rx_byte_vld) begin
                unique case (state)
                    StIdle: begin
                        idx <= '0;
                        if (rx_byte == CR || rx_byte == LF) begin
                            state <= StIdle;
                        end else if (rx_byte == CH_O) begin
                            kw    <= KwOk;
                            state <= StKw;
                        end else if (rx_byte == CH_E) begin
                            kw    <= KwErr;
                            state <= StKw;
                        end else if (rx_byte == PLUS) begin
                            kw    <= KwIpd;
                            state <= StKw;
                        end else begin
                            state <= StSkip;
                        end
                    end

                    StKw: begin
                        if (rx_byte == kw_byte(kw, idx)) begin
                            if (idx == kw_last(kw)) begin
                                case (kw)
                                    KwOk: begin
                                        ok_pulse <= 1'b1;
                                        state    <= StIdle;
                                    end
                                    KwErr: begin
                                        err_pulse <= 1'b1;
                                        state     <= StIdle;
                                    end
                                    default: begin
                                        acc   <= '0;
                                        dcnt  <= '0;
                                        state <= StLen;
                                    end
                                endcase
                            end else begin
                                idx <= idx + 3'd1;
                            end
                        end else begin
                            state <= (rx_byte == LF) ? StIdle : StSkip;
                        end
                    end

                    StLen: begin
                        if (is_digit && dcnt < 3'd5) begin
                            acc  <= acc_next;
                            dcnt <= dcnt + 3'd1;
                        end else if (rx_byte == COLON && len_ok) begin
                            ipd_len   <= acc[15:0];
                            rem       <= acc[15:0];
                            ipd_start <= 1'b1;
                            state     <= StData;
                        end else begin
                            fmt_err <= 1'b1;
                            state   <= (rx_byte == LF) ? StIdle : StSkip;
                        end
                    end

                    StData: begin
                        ipd_data <= rx_byte;
                        ipd_vld  <= 1'b1;
                        rem      <= rem - 16'd1;
                        if (rem == 16'd1) begin
                            ipd_done <= 1'b1;
                            state    <= StIdle;
                        end
                    end

                    StSkip: begin
                        if (rx_byte == LF) begin
                            state <= StIdle;
                        end
                    end

                    default: state <= StIdle;
                endcase
            end else if (tmo_expired) begin
                tmo_pulse <= 1'b1;
                state     <= StIdle;
            end
        end
    end

endmodule
